// File: rtl/video_timing_if.sv
// Video source bundle: hs/vs/de timing plus the pixel request/coordinates that lead de by one cycle.
// pix_req_o has no back-pressure: when it is 1, the source must present pixel (req_x_o, req_y_o) on the next cycle.
interface video_timing_if;
  logic        pix_req_o;
  logic [11:0] req_x_o;
  logic [11:0] req_y_o;
  logic        vout_hs_o;
  logic        vout_vs_o;
  logic        vout_de_o;
  logic        sof_o;
  logic        busy_o;

  modport master (
    output pix_req_o, req_x_o, req_y_o, vout_hs_o, vout_vs_o, vout_de_o, sof_o, busy_o
  );

  modport slave (
    input pix_req_o, req_x_o, req_y_o, vout_hs_o, vout_vs_o, vout_de_o, sof_o, busy_o
  );
endinterface

// File: rtl/video_timing_gen.sv
// Fixed-raster video timing generator: h/v counters drive a combinational pixel request
// and registered hs/vs/de/sof/busy one cycle later.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic           vin_clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  output logic           dbg_state_o,
  video_timing_if.master vout
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL exceeds 4096");
  end

  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly.
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [12:0] h_ext, v_ext;
  logic        run, pix_req, hs_act, vs_act, sof_d;

  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      h_q     <= 12'd0;
      v_q     <= 12'd0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // en_i only matters while idle or on the last cycle of a frame; a frame always completes.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = 12'd0;
        v_d = 12'd0;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = 12'd0;
          if (v_q == V_LAST) begin
            v_d     = 12'd0;
            state_d = en_i ? ST_RUN : ST_IDLE;
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    h_ext   = {1'b0, h_q};
    v_ext   = {1'b0, v_q};
    run     = (state_q == ST_RUN);
    pix_req = run && (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_act  = run && (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_act  = run && (v_ext >= VS_BEG) && (v_ext < VS_END);
    sof_d   = run && (h_q == 12'd0) && (v_q == 12'd0);
  end

  assign vout.pix_req_o = pix_req;
  assign vout.req_x_o   = pix_req ? h_q : 12'd0;
  assign vout.req_y_o   = pix_req ? v_q : 12'd0;
  assign dbg_state_o    = (state_q == ST_RUN);

  // All registered outputs decode the same counter snapshot, so they stay zero-skew.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vout.vout_de_o <= 1'b0;
      vout.vout_hs_o <= ~HS_POL;
      vout.vout_vs_o <= ~VS_POL;
      vout.sof_o     <= 1'b0;
      vout.busy_o    <= 1'b0;
    end else begin
      vout.vout_de_o <= pix_req;
      vout.vout_hs_o <= hs_act ? HS_POL : ~HS_POL;
      vout.vout_vs_o <= vs_act ? VS_POL : ~VS_POL;
      vout.sof_o     <= sof_d;
      vout.busy_o    <= run;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on an 8x6 raster: driver pushes per-cycle expected vectors,
// a negedge monitor pops and compares them, and directed checks cover counts, spacing and reset.
module tb_video_timing_gen;

  logic clk;
  logic rst_ni;
  logic en_i;
  logic dbg_state;

  video_timing_if vif ();

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .vin_clk_i  (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .dbg_state_o(dbg_state),
    .vout       (vif)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [30:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, sof_cnt = 0, busy_cnt = 0;
  int sof_prev = -1;
  int gap_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [30:0] act, exp;
    cyc++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {dbg_state, vif.pix_req_o, vif.req_x_o, vif.req_y_o,
             vif.vout_hs_o, vif.vout_vs_o, vif.vout_de_o, vif.sof_o, vif.busy_o};
      chk("cycle_vec", {1'b0, act}, {1'b0, exp});
    end
    if (vif.vout_de_o) de_cnt++;
    if (vif.vout_hs_o) hs_cnt++;
    if (vif.vout_vs_o) vs_cnt++;
    if (vif.busy_o)    busy_cnt++;
    if (vif.sof_o) begin
      sof_cnt++;
      if (sof_prev >= 0) gap_q.push_back(cyc - sof_prev);
      sof_prev = cyc;
    end
  end

  // ---------------- reference of the 8x6 test raster ----------------
  // Line: cols 0..3 active, 4 FP, 5..6 sync, 7 BP. Frame: lines 0..2 active, 3 FP, 4 sync, 5 BP.
  logic m_run = 1'b0;
  int   m_p   = 0;
  logic e_hs = 0, e_vs = 0, e_de = 0, e_sof = 0, e_busy = 0;

  function automatic logic [30:0] build_vec();
    int   col  = m_p % 8;
    int   line = m_p / 8;
    logic pix  = m_run && (col < 4) && (line < 3);
    return {m_run, pix, pix ? 12'(col) : 12'd0, pix ? 12'(line) : 12'd0,
            e_hs, e_vs, e_de, e_sof, e_busy};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_p = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_sof = 0; e_busy = 0;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic en, input logic rst = 1'b1);
    int col, line;
    @(negedge clk);
    en_i   = en;
    rst_ni = rst;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      col    = m_p % 8;
      line   = m_p / 8;
      e_de   = m_run && (col < 4) && (line < 3);
      e_hs   = m_run && (col == 5 || col == 6);
      e_vs   = m_run && (line == 4);
      e_sof  = m_run && (m_p == 0);
      e_busy = m_run;
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_p = 0; end
      end else if (m_p == 47) begin
        m_p = 0; m_run = en;
      end else begin
        m_p++;
      end
    end
    #1;
    exp_q.push_back(build_vec());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int de0, hs0, vs0, sof0, busy0;
    rst_ni = 1'b0;
    en_i   = 1'b0;
    #1;
    chk("reset_pix_req", 32'(vif.pix_req_o), 32'd0);
    chk("reset_hs",      32'(vif.vout_hs_o), 32'd0);
    chk("reset_vs",      32'(vif.vout_vs_o), 32'd0);
    chk("reset_de",      32'(vif.vout_de_o), 32'd0);
    chk("reset_sof_busy", {30'd0, vif.sof_o, vif.busy_o}, 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // idle with en_i low
    repeat (20) tick(1'b0);

    // frame A with en high, frame B with en dropped at frame cycle 10
    @(negedge clk); #1;
    de0 = de_cnt; hs0 = hs_cnt; vs0 = vs_cnt; sof0 = sof_cnt;
    tick(1'b1);
    chk("first_req_valid", 32'(vif.pix_req_o), 32'd1);
    chk("first_req_xy", {8'd0, vif.req_x_o, vif.req_y_o}, 32'd0);
    repeat (47) tick(1'b1);
    tick(1'b1);
    repeat (9)  tick(1'b1);
    repeat (38) tick(1'b0);
    tick(1'b0);
    repeat (4) tick(1'b0);
    @(negedge clk); #1;
    chk("de_count_2frames",  32'(de_cnt - de0),   32'd24);
    chk("hs_count_2frames",  32'(hs_cnt - hs0),   32'd24);
    chk("vs_count_2frames",  32'(vs_cnt - vs0),   32'd16);
    chk("sof_count_2frames", 32'(sof_cnt - sof0), 32'd2);
    chk("sof_gap_ab", 32'(gap_q[gap_q.size()-1]), 32'd48);
    chk("busy_after_stop", 32'(vif.busy_o), 32'd0);

    // three back-to-back frames
    gap_q.delete();
    sof0 = sof_cnt; busy0 = busy_cnt;
    tick(1'b1);
    repeat (143) tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);
    @(negedge clk); #1;
    chk("sof_count_3frames",  32'(sof_cnt - sof0),   32'd3);
    chk("busy_count_3frames", 32'(busy_cnt - busy0), 32'd144);
    chk("gap_entries", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("sof_gap_1", 32'(gap_q[1]), 32'd48);
      chk("sof_gap_2", 32'(gap_q[2]), 32'd48);
    end

    // reset asserted mid-frame at frame cycle 20
    tick(1'b1);
    repeat (20) tick(1'b1);
    chk("de_before_rst", 32'(vif.vout_de_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_de",   32'(vif.vout_de_o), 32'd0);
    chk("rst_async_sync", {30'd0, vif.vout_hs_o, vif.vout_vs_o}, 32'd0);
    chk("rst_async_sof_busy", {30'd0, vif.sof_o, vif.busy_o}, 32'd0);
    chk("rst_async_req",  32'(vif.pix_req_o), 32'd0);
    exp_q.delete();
    model_reset();
    exp_q.push_back(build_vec());
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("restart_req", 32'(vif.pix_req_o), 32'd1);
    chk("restart_no_sof_yet", 32'(vif.sof_o), 32'd0);
    tick(1'b1);
    chk("restart_sof", 32'(vif.sof_o), 32'd1);
    chk("restart_req_x", 32'(vif.req_x_o), 32'd1);
    repeat (46) tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);

    @(negedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
